traffic_phase_scheduler: RTL and testbench

Phase scheduler for a two-road intersection (road A, road B) with a shared pedestrian crossing and a maintenance flash mode. It sequences the green, yellow and all-red phases from per-phase tick budgets. It grants a pedestrian walk phase between road changes when requested. It sits behind the 1 Hz divider: the divider supplies a one-cycle `tick` strobe, and this block drives the lamp outputs directly.

---
 rtl/traffic_phase_scheduler.sv | 143 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler with pedestrian walk insertion and flash mode.
// Phases advance on the 1 Hz tick strobe; lamps decode directly from the registered state.
module traffic_phase_scheduler #(
  parameter int CW       = 4,
  parameter int GRN_A_T  = 3,
  parameter int GRN_B_T  = 4,
  parameter int YEL_T    = 1,
  parameter int ALLRED_T = 1,
  parameter int PED_T    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       off,
  input  logic       ped_btn,
  output logic [2:0] LightA,
  output logic [2:0] LightB,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,
    PED    = 3'd6,
    FLASH  = 3'd7
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d, dur;
  logic            flash_ph, flash_ph_d;
  logic            next_b, next_b_d;
  logic            ped_pend_d;

  always_comb begin
    dur = CW'(ALLRED_T);
    case (state)
      A_GRN:   dur = CW'(GRN_A_T);
      A_YEL:   dur = CW'(YEL_T);
      B_GRN:   dur = CW'(GRN_B_T);
      B_YEL:   dur = CW'(YEL_T);
      PED:     dur = CW'(PED_T);
      default: dur = CW'(ALLRED_T);
    endcase
  end

  // off overrides everything except reset; the ped latch runs on every edge.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    flash_ph_d = flash_ph;
    next_b_d   = next_b;
    ped_pend_d = ped_pend | ped_btn;
    if (off) begin
      if (state != FLASH) begin
        state_d    = FLASH;
        cnt_d      = CW'(1);
        flash_ph_d = 1'b0;
      end else if (tick) begin
        flash_ph_d = ~flash_ph;
      end
    end else if (tick) begin
      if (state == FLASH) begin
        state_d    = RED_BA;
        cnt_d      = CW'(1);
        next_b_d   = 1'b0;
        flash_ph_d = 1'b0;
      end else if (cnt < dur) begin
        cnt_d = cnt + CW'(1);
      end else begin
        cnt_d = CW'(1);
        case (state)
          A_GRN:  state_d = A_YEL;
          A_YEL:  state_d = RED_AB;
          RED_AB: begin
            if (ped_pend) begin
              state_d    = PED;
              next_b_d   = 1'b1;
              ped_pend_d = 1'b0;
            end else begin
              state_d = B_GRN;
            end
          end
          B_GRN:  state_d = B_YEL;
          B_YEL:  state_d = RED_BA;
          RED_BA: begin
            if (ped_pend) begin
              state_d    = PED;
              next_b_d   = 1'b0;
              ped_pend_d = 1'b0;
            end else begin
              state_d = A_GRN;
            end
          end
          PED:     state_d = next_b ? B_GRN : A_GRN;
          default: state_d = A_GRN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= A_GRN;
      cnt      <= CW'(1);
      flash_ph <= 1'b0;
      next_b   <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      flash_ph <= flash_ph_d;
      next_b   <= next_b_d;
      ped_pend <= ped_pend_d;
    end
  end

  always_comb begin
    LightA = 3'b100;
    LightB = 3'b100;
    walk   = 1'b0;
    case (state)
      A_GRN:   LightA = 3'b001;
      A_YEL:   LightA = 3'b010;
      B_GRN:   LightB = 3'b001;
      B_YEL:   LightB = 3'b010;
      PED:     walk   = 1'b1;
      FLASH: begin
        LightA = {1'b0, flash_ph, 1'b0};
        LightB = {1'b0, flash_ph, 1'b0};
      end
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: vector tables with a scoreboard queue,
// plus a hand-driven asynchronous reset in the middle of a yellow phase.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       off = 1'b0;
  logic       ped_btn = 1'b0;
  logic [2:0] LightA, LightB, phase;
  logic       walk, ped_pend;

  traffic_phase_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .off(off), .ped_btn(ped_btn),
    .LightA(LightA), .LightB(LightB), .walk(walk), .ped_pend(ped_pend), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       off;
    logic       btn;
    logic [2:0] ph;
    logic       pend;
    logic       fph;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          seq11[11]   = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 5};
  int          pedseq[17]  = '{0, 0, 0, 1, 2, 6, 6, 6, 6, 6, 3, 3, 3, 3, 4, 5, 0};

  // Expected bundle {phase, LightA, LightB, walk, ped_pend} from an expected phase.
  function automatic logic [10:0] expect_of(logic [2:0] ph, logic fph, logic pend);
    logic [2:0] a, b;
    a = 3'b100;
    b = 3'b100;
    case (ph)
      3'd0: a = 3'b001;
      3'd1: a = 3'b010;
      3'd3: b = 3'b001;
      3'd4: b = 3'b010;
      3'd7: begin a = {1'b0, fph, 1'b0}; b = {1'b0, fph, 1'b0}; end
      default: ;
    endcase
    return {ph, a, b, (ph == 3'd6), pend};
  endfunction

  function automatic logic [10:0] dut_bundle();
    return {phase, LightA, LightB, walk, ped_pend};
  endfunction

  task automatic compare(string name, logic [10:0] act, logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ph=%0d A=%b B=%b walk=%b pend=%b, want ph=%0d A=%b B=%b walk=%b pend=%b",
               name, act[10:8], act[7:5], act[4:2], act[1], act[0],
               exp[10:8], exp[7:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic add(logic tk, logic of, logic bt, int ph, logic pend, logic fph);
    vec_t v;
    v.tick = tk; v.off = of; v.btn = bt; v.ph = 3'(ph); v.pend = pend; v.fph = fph;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(string name);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      tick    = vecs[i].tick;
      off     = vecs[i].off;
      ped_btn = vecs[i].btn;
      exp_q.push_back(expect_of(vecs[i].ph, vecs[i].fph, vecs[i].pend));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s[%0d]: scoreboard empty", name, i);
      end else begin
        compare($sformatf("%s[%0d]", name, i), dut_bundle(), exp_q.pop_front());
      end
    end
    vecs.delete();
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    tick = 1'b0; off = 1'b0; ped_btn = 1'b0;
    reset = 1'b1;
    #1;
    compare(name, dut_bundle(), expect_of(3'd0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Pedestrian request at cycle btn_at with a tick every 'period' cycles.
  task automatic add_ped_run(int period, int btn_at, int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      int t;
      t = (i + 1) / period;
      add(((i + 1) % period) == 0, 1'b0, i == btn_at, pedseq[t], t < 5, 1'b0);
    end
  endtask

  initial begin
    do_reset("reset_initial");

    for (int k = 1; k <= 22; k++) add(1'b1, 1'b0, 1'b0, seq11[k % 11], 1'b0, 1'b0);
    run_vecs("cycle");

    do_reset("reset_ped");
    add_ped_run(1, 0, 16);
    run_vecs("ped_single");

    do_reset("reset_multi");
    add(1, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 0); add(1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0); add(1, 0, 0, 2, 1, 0);
    add(1, 0, 1, 6, 0, 0);
    add(1, 0, 0, 6, 0, 0); add(1, 0, 1, 6, 1, 0); add(1, 0, 0, 6, 1, 0); add(1, 0, 0, 6, 1, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 3, 1, 0);
    add(1, 0, 0, 4, 1, 0); add(1, 0, 0, 5, 1, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 0, 6, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    run_vecs("ped_multi");

    do_reset("reset_slow");
    add_ped_run(3, 0, 48);
    run_vecs("slow_tick");

    do_reset("reset_flash");
    for (int k = 1; k <= 5; k++) add(1'b1, 1'b0, 1'b0, seq11[k], 1'b0, 1'b0);
    add(0, 1, 0, 7, 0, 0); add(1, 1, 0, 7, 0, 1); add(0, 1, 0, 7, 0, 1);
    add(1, 1, 0, 7, 0, 0); add(1, 1, 0, 7, 0, 1); add(0, 0, 0, 7, 0, 1);
    add(1, 0, 0, 5, 0, 0);
    add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0);
    run_vecs("flash");

    do_reset("reset_pre_async");
    for (int k = 1; k <= 9; k++) add(1'b1, 1'b0, k == 6, seq11[k], k >= 6, 1'b0);
    run_vecs("to_b_yel");
    #2;
    reset = 1'b1;
    #1;
    compare("async_reset", dut_bundle(), expect_of(3'd0, 1'b0, 1'b0));
    @(negedge clk);
    tick = 1'b0; ped_btn = 1'b0;
    reset = 1'b0;
    add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 1, 0, 0);
    run_vecs("after_async");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
